// File: rtl/fabric_output_checker.sv
// Hardware response checker: compares fabric outputs against a golden benchmark
// over a programmed run, counts mismatch episodes and produces a pass/fail verdict.
module fabric_output_checker #(
    parameter int WIDTH       = 1,
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 16,
    parameter int SKIP_CYCLES = 1,
    parameter int RUN_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] gfpga_out,
    input  logic [WIDTH-1:0] bench_out,
    input  logic [WIDTH-1:0] bench_valid,
    output logic             busy,
    output logic             mismatch_flag,
    output logic             err_pulse,
    output logic [ERR_W-1:0] nb_error,
    output logic [CNT_W-1:0] first_err_cycle,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;

    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cycle_cnt;
    logic [ERR_W-1:0] nb_error_next;
    logic             cmp;
    logic             start_ok;
    logic             skip_last;
    logic             run_last;
    logic             new_err;

    assign cmp       = |((gfpga_out ^ bench_out) & bench_valid);
    assign start_ok  = start && (state == IDLE || state == DONE);
    assign skip_last = (cycle_cnt == SKIP_LAST);
    assign run_last  = (cycle_cnt == RUN_LAST);
    assign new_err   = (state == CHECK) && cmp && !mismatch_flag;
    assign busy      = (state == SKIP) || (state == CHECK);
    assign done      = (state == DONE);

    // Episode counter saturates instead of wrapping
    always_comb begin
        nb_error_next = nb_error;
        if (new_err && nb_error != '1)
            nb_error_next = nb_error + ERR_W'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (SKIP_CYCLES == 0) ? CHECK : SKIP;
            SKIP:       if (skip_last) state_next = CHECK;
            CHECK:      if (run_last) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // The cycle counter doubles as the skip timer and restarts at 0 for CHECK
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt       <= '0;
            nb_error        <= '0;
            first_err_cycle <= '0;
            mismatch_flag   <= 1'b0;
            err_pulse       <= 1'b0;
            pass            <= 1'b0;
        end else if (start_ok) begin
            cycle_cnt       <= '0;
            nb_error        <= '0;
            first_err_cycle <= '0;
            mismatch_flag   <= 1'b0;
            err_pulse       <= 1'b0;
            pass            <= 1'b0;
        end else begin
            case (state)
                SKIP: begin
                    err_pulse <= 1'b0;
                    cycle_cnt <= skip_last ? '0 : cycle_cnt + CNT_W'(1);
                end
                CHECK: begin
                    mismatch_flag <= cmp;
                    err_pulse     <= new_err;
                    nb_error      <= nb_error_next;
                    if (new_err && nb_error == '0)
                        first_err_cycle <= cycle_cnt;
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (run_last)
                        pass <= (nb_error_next == '0);
                end
                DONE: begin
                    mismatch_flag <= 1'b0;
                    err_pulse     <= 1'b0;
                end
                default: err_pulse <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_output_checker.sv
// Self-checking bench for fabric_output_checker: two instances (skip/no-skip,
// wide/saturating) driven by directed and random runs against a run-level model.
module tb_fabric_output_checker;

    logic clk = 1'b0;
    logic reset;

    logic        a_start;
    logic [1:0]  a_g, a_b, a_v;
    logic        a_busy, a_mflag, a_pulse, a_done, a_pass;
    logic [15:0] a_nb, a_first;

    logic        b_start;
    logic [0:0]  b_g, b_b, b_v;
    logic        b_busy, b_mflag, b_pulse, b_done, b_pass;
    logic [1:0]  b_nb;
    logic [15:0] b_first;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] sg [0:15];
    logic [1:0] sb [0:15];
    logic [1:0] sv [0:15];

    logic [31:0] o_busy, o_mflag, o_pulse, o_nb, o_first, o_done, o_pass;

    fabric_output_checker #(.WIDTH(2), .CNT_W(16), .ERR_W(16), .SKIP_CYCLES(1), .RUN_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .start(a_start),
        .gfpga_out(a_g), .bench_out(a_b), .bench_valid(a_v),
        .busy(a_busy), .mismatch_flag(a_mflag), .err_pulse(a_pulse),
        .nb_error(a_nb), .first_err_cycle(a_first), .done(a_done), .pass(a_pass)
    );

    fabric_output_checker #(.WIDTH(1), .CNT_W(16), .ERR_W(2), .SKIP_CYCLES(0), .RUN_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .gfpga_out(b_g), .bench_out(b_b), .bench_valid(b_v),
        .busy(b_busy), .mismatch_flag(b_mflag), .err_pulse(b_pulse),
        .nb_error(b_nb), .first_err_cycle(b_first), .done(b_done), .pass(b_pass)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic sampleOutputs(input int sel);
        if (sel == 0) begin
            o_busy = 32'(a_busy); o_mflag = 32'(a_mflag); o_pulse = 32'(a_pulse);
            o_nb = 32'(a_nb); o_first = 32'(a_first); o_done = 32'(a_done); o_pass = 32'(a_pass);
        end else begin
            o_busy = 32'(b_busy); o_mflag = 32'(b_mflag); o_pulse = 32'(b_pulse);
            o_nb = 32'(b_nb); o_first = 32'(b_first); o_done = 32'(b_done); o_pass = 32'(b_pass);
        end
    endtask

    task automatic driveCycle(input int sel, input int k);
        if (sel == 0) begin
            a_g = sg[k]; a_b = sb[k]; a_v = sv[k];
        end else begin
            b_g = sg[k][0:0]; b_b = sb[k][0:0]; b_v = sv[k][0:0];
        end
    endtask

    task automatic fillEqual();
        for (int k = 0; k < 16; k++) begin
            sg[k] = 2'b00; sb[k] = 2'b00; sv[k] = 2'b11;
        end
    endtask

    task automatic fillRandom();
        for (int k = 0; k < 16; k++) begin
            sg[k] = 2'($urandom);
            sb[k] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : sg[k];
            sv[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        end
    endtask

    // One full run from IDLE/DONE: start pulse, skip and check cycles, verdict, hold
    task automatic applyStimulus(input int sel, input string name);
        int  skip, run, emax, episodes, first, exp_nb;
        logic [1:0] mask;
        bit  cmpv [0:15];
        bit  prev;
        skip = (sel == 0) ? 1 : 0;
        run  = (sel == 0) ? 4 : 8;
        emax = (sel == 0) ? 65535 : 3;
        mask = (sel == 0) ? 2'b11 : 2'b01;
        episodes = 0;
        first = 0;
        for (int j = 0; j < run; j++) begin
            cmpv[j] = |((sg[skip+j] ^ sb[skip+j]) & sv[skip+j] & mask);
            prev = (j > 0) ? cmpv[j-1] : 1'b0;
            if (cmpv[j] && !prev) begin
                if (episodes == 0) first = j;
                episodes++;
            end
        end
        exp_nb = (episodes > emax) ? emax : episodes;

        if (sel == 0) a_start = 1'b1; else b_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; b_start = 1'b0;
        sampleOutputs(sel);
        checkOutput({name, ".start_busy"}, o_busy, 1);
        checkOutput({name, ".start_nb"}, o_nb, 0);
        checkOutput({name, ".start_flag"}, o_mflag, 0);
        checkOutput({name, ".start_done"}, o_done, 0);

        for (int k = 0; k < skip + run; k++) begin
            driveCycle(sel, k);
            @(posedge clk); #1;
            sampleOutputs(sel);
            if (k < skip) begin
                checkOutput({name, ".skip_flag"}, o_mflag, 0);
                checkOutput({name, ".skip_pulse"}, o_pulse, 0);
                checkOutput({name, ".skip_busy"}, o_busy, 1);
            end else begin
                prev = (k - skip > 0) ? cmpv[k-skip-1] : 1'b0;
                checkOutput($sformatf("%s.flag%0d", name, k - skip), o_mflag, 32'(cmpv[k-skip]));
                checkOutput($sformatf("%s.pulse%0d", name, k - skip), o_pulse, 32'(cmpv[k-skip] && !prev));
                checkOutput($sformatf("%s.busy%0d", name, k - skip), o_busy, 32'(k != skip + run - 1));
            end
        end
        checkOutput({name, ".done"}, o_done, 1);
        checkOutput({name, ".nb_error"}, o_nb, 32'(exp_nb));
        checkOutput({name, ".first_err"}, o_first, 32'(first));
        checkOutput({name, ".pass"}, o_pass, 32'(episodes == 0));

        driveCycle(sel, 0);
        @(posedge clk); #1;
        sampleOutputs(sel);
        checkOutput({name, ".hold_flag"}, o_mflag, 0);
        checkOutput({name, ".hold_pulse"}, o_pulse, 0);
        checkOutput({name, ".hold_done"}, o_done, 1);
        checkOutput({name, ".hold_nb"}, o_nb, 32'(exp_nb));
        checkOutput({name, ".hold_pass"}, o_pass, 32'(episodes == 0));
    endtask

    initial begin
        reset = 1'b1;
        a_start = 1'b0; a_g = '0; a_b = '0; a_v = '0;
        b_start = 1'b0; b_g = '0; b_b = '0; b_v = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sampleOutputs(s);
            checkOutput("reset.busy", o_busy, 0);
            checkOutput("reset.done", o_done, 0);
            checkOutput("reset.nb", o_nb, 0);
            checkOutput("reset.pass", o_pass, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        fillEqual();
        applyStimulus(0, "equal");

        fillEqual();
        sg[0] = 2'b01;
        applyStimulus(0, "skip_only");

        fillEqual();
        sg[2] = 2'b01; sg[3] = 2'b01;
        applyStimulus(0, "one_episode");

        fillEqual();
        sg[1] = 2'b01; sg[3] = 2'b01;
        applyStimulus(0, "two_episodes");

        fillEqual();
        for (int k = 0; k < 16; k++) begin
            sg[k] = 2'b10; sv[k] = 2'b01;
        end
        applyStimulus(0, "masked_bit");
        for (int k = 0; k < 16; k++) sv[k] = 2'b11;
        applyStimulus(0, "unmasked_bit");

        // Mid-run reset after one counted error
        fillEqual();
        sg[2] = 2'b01;
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            driveCycle(0, k);
            @(posedge clk); #1;
        end
        sampleOutputs(0);
        checkOutput("midrun.nb_before", o_nb, 1);
        driveCycle(0, 3);
        #2 reset = 1'b1;
        #1;
        sampleOutputs(0);
        checkOutput("midrun.busy", o_busy, 0);
        checkOutput("midrun.flag", o_mflag, 0);
        checkOutput("midrun.pulse", o_pulse, 0);
        checkOutput("midrun.nb", o_nb, 0);
        checkOutput("midrun.first", o_first, 0);
        checkOutput("midrun.done", o_done, 0);
        checkOutput("midrun.pass", o_pass, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        fillEqual();
        sg[4] = 2'b01;
        applyStimulus(0, "last_cycle");
        fillEqual();
        sg[1] = 2'b01;
        applyStimulus(0, "restart_first");

        for (int r = 0; r < 6; r++) begin
            fillRandom();
            applyStimulus(0, $sformatf("rand_a%0d", r));
        end

        fillEqual();
        for (int k = 0; k < 8; k += 2) sg[k] = 2'b01;
        applyStimulus(1, "saturate");

        fillEqual();
        for (int k = 0; k < 8; k++) sg[k] = 2'b01;
        applyStimulus(1, "all_mismatch");

        fillEqual();
        applyStimulus(1, "b_equal");

        for (int r = 0; r < 4; r++) begin
            fillRandom();
            applyStimulus(1, $sformatf("rand_b%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fabric_output_checker.md
Name: fabric_output_checker

Overview:
Synthesizable response checker for the formal-verification flow, i.e. the receiving end of random-stimulus testing. It runs in hardware next to the FPGA fabric, with no simulator involved. It compares the fabric outputs against reference benchmark outputs on every clock and flags mismatches. It counts mismatch episodes and gives a pass/fail verdict after a programmed run length. Each instance sits beside a fabric-under-test and its golden benchmark in on-chip self-test wrappers.

Parameters:
WIDTH, 1, number of compared output bits (gfpga vs bench)
CNT_W, 16, width of the run-cycle counter and first-error timestamp
ERR_W, 16, width of the error counter (saturating)
SKIP_CYCLES, 1, initial clocks after start with no comparison (initialization edge skip)
RUN_CYCLES, 4, number of compared clocks per run; must be >= 1 and < 2**CNT_W

Ports:
clk  input  1  checker clock, rising-edge active
reset  input  1  asynchronous, active-high reset
start  input  1  1-cycle pulse; begins a run when in IDLE or DONE
gfpga_out  input  WIDTH  outputs of the FPGA fabric under test
bench_out  input  WIDTH  outputs of the reference benchmark
bench_valid  input  WIDTH  per-bit compare enable; 0 = bench bit unknown/don't-care (hardware stand-in for X)
busy  output  1  high in SKIP or CHECK
mismatch_flag  output  1  registered mismatch indicator for the previous compared cycle
err_pulse  output  1  1-cycle pulse on each rising edge of the mismatch condition
nb_error  output  ERR_W  count of mismatch episodes in the current/last run
first_err_cycle  output  CNT_W  CHECK-cycle index (0-based) of the first counted error
done  output  1  high in DONE
pass  output  1  valid when done=1; 1 iff nb_error==0

Behaviour:
- reset asserted (async): state=IDLE. busy, mismatch_flag, err_pulse, nb_error, first_err_cycle, done and pass all go to 0. The cycle counter goes to 0.
- FSM states: IDLE, SKIP, CHECK, DONE.
- IDLE --start--> SKIP, or --start--> CHECK directly if SKIP_CYCLES==0.
- DONE --start--> same as from IDLE (restart).
- start is ignored in SKIP and CHECK.
- On accepted start (same edge), these clear: nb_error=0, first_err_cycle=0, cycle counter=0, mismatch_flag=0, done=0, pass=0.
- SKIP: stays exactly SKIP_CYCLES clocks, with no comparison and no counting, then goes to CHECK.
- CHECK, every clock: cmp = OR-reduce((gfpga_out ^ bench_out) & bench_valid). mismatch_flag <= cmp, so it has 1-cycle latency.
- err_pulse <= cmp & ~mismatch_flag. An error is counted per episode; a mismatch lasting N consecutive cycles counts once.
- On err_pulse-qualifying edge:
  - nb_error increments, saturating at 2**ERR_W-1 (it never wraps).
  - If nb_error was 0, first_err_cycle <= current cycle counter value.
- The cycle counter increments each CHECK clock. On the clock where counter == RUN_CYCLES-1: compare as normal, then move to DONE, so exactly RUN_CYCLES compares happen.
- Entering DONE:
  - done=1 and busy=0.
  - mismatch_flag and err_pulse clear on the following clock. The last-cycle error is already counted on the transition edge.
  - pass = (nb_error_next == 0), so it includes an error detected on the final compare.
- DONE holds nb_error, first_err_cycle and pass stable until start or reset.
- bench_valid bit = 0: that bit never contributes to cmp, whatever the data.
- reset mid-run: immediate return to IDLE with all outputs cleared; no partial verdict is kept.
- Mismatch persisting across DONE then restart: the flag is cleared at start, so a mismatch on the first CHECK cycle of the new run counts as a new error.

Test Plan:
- Defaults, WIDTH=1, gfpga==bench for all cycles. start -> busy for 5 clocks (1 SKIP + 4 CHECK), then done=1, pass=1, nb_error=0, err_pulse never high.
- Mismatch only in the SKIP cycle (gfpga=1, bench=0), equal afterwards -> nb_error=0, pass=1.
- Mismatch on CHECK cycles 1 and 2 (one episode), equal elsewhere -> single err_pulse one clock after cycle 1, nb_error=1, first_err_cycle=1, pass=0.
- Mismatch on CHECK cycles 0 and 2 (two episodes) -> two err_pulses, nb_error=2, first_err_cycle=0.
- WIDTH=2, bench_valid=2'b01, bit1 always mismatching, bit0 equal -> nb_error=0, pass=1. Then bench_valid=2'b11 -> nb_error=1, first_err_cycle=0.
- Assert reset during CHECK cycle 2 after one error -> all outputs 0 immediately, state IDLE. Then start with a mismatch only on the last CHECK cycle -> nb_error=1, first_err_cycle=3, done=1, pass=0.
- ERR_W=2 with alternating mismatch/match for 8 CHECK cycles (RUN_CYCLES=8) -> nb_error saturates at 3, no wrap.
